// File: rtl/priv_control_unit.sv
// RV32I main decoder with Machine/User privilege FSM, trap sequencing and pipe flush.
// Latency: decode outputs are combinational (zero latency); mode/trap state updates at the accepting posedge.
// Backpressure: instr_ready drops for exactly FLUSH_CYCLES cycles after each trap; valid without ready is ignored.
//
// Ports: clock/reset (async active-low); instr_valid/instr_ready handshake; opcode/funct3 of the
// decode-stage instruction; gated decode strobes, ALU/PC/operand/extend selects and ungated rs1/rs2
// usage; mode/userMode; trap_valid/trap_cause/trap_prev_mode/flush; saturating illegal_cnt and
// user_cycles; report enables the per-cycle trace.
// Optional build: define PRIV_CTRL_REPORT_EN for the per-cycle $display trace (simulation aid only).
module priv_control_unit #(
    parameter int           CORE             = 0,
    parameter int           FLUSH_CYCLES     = 2,
    parameter int           CNT_W            = 16,
    parameter logic [6:0]   CUSTOM0_OPCODE   = 7'b0001011,
    parameter int           PRINT_CYCLES_MIN = 1,
    parameter int           PRINT_CYCLES_MAX = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    output logic             branch_op,
    output logic             memRead,
    output logic             memtoReg,
    output logic             memWrite,
    output logic             regWrite,
    output logic [2:0]       ALUOp,
    output logic [1:0]       next_PC_sel,
    output logic [1:0]       operand_A_sel,
    output logic             operand_B_sel,
    output logic [1:0]       extend_sel,
    output logic             rs1_used,
    output logic             rs2_used,
    output logic [1:0]       mode,
    output logic             userMode,
    output logic             trap_valid,
    output logic [3:0]       trap_cause,
    output logic [1:0]       trap_prev_mode,
    output logic             flush,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [CNT_W-1:0] user_cycles,
    input  logic             report
);

    localparam logic [1:0] M_MODE = 2'b00;
    localparam logic [1:0] U_MODE = 2'b01;
    localparam logic [1:0] FLUSH  = 2'b10;

    logic [1:0] state;
    logic [3:0] flush_cnt;
    logic       ready_q;    // holds instr_ready low until the first clock after reset release

    // raw (ungated) decode
    logic       known, is_custom0, is_system;
    logic       rw_raw, mr_raw, mw_raw, br_raw;
    logic [1:0] pc_raw;

    logic       accept, trap_det, issue;
    logic [3:0] trap_code;

    assign is_custom0 = (opcode == CUSTOM0_OPCODE);

    always_comb begin
        known         = 1'b1;
        is_system     = 1'b0;
        rw_raw        = 1'b0;
        mr_raw        = 1'b0;
        mw_raw        = 1'b0;
        br_raw        = 1'b0;
        pc_raw        = 2'b00;
        ALUOp         = 3'b111;
        operand_A_sel = 2'b00;
        operand_B_sel = 1'b0;
        extend_sel    = 2'b00;
        rs1_used      = 1'b0;
        rs2_used      = 1'b0;
        if (!is_custom0) begin
            case (opcode)
                7'b0110011: begin                       // R
                    rw_raw = 1'b1; ALUOp = 3'b010; rs1_used = 1'b1; rs2_used = 1'b1;
                end
                7'b0010011: begin                       // I
                    rw_raw = 1'b1; ALUOp = 3'b011; operand_B_sel = 1'b1; rs1_used = 1'b1;
                end
                7'b0000011: begin                       // LOAD
                    rw_raw = 1'b1; mr_raw = 1'b1; ALUOp = 3'b000;
                    operand_B_sel = 1'b1; rs1_used = 1'b1;
                end
                7'b0100011: begin                       // STORE
                    mw_raw = 1'b1; ALUOp = 3'b000; operand_B_sel = 1'b1;
                    extend_sel = 2'b01; rs1_used = 1'b1; rs2_used = 1'b1;
                end
                7'b1100011: begin                       // BRANCH
                    br_raw = 1'b1; pc_raw = 2'b01; ALUOp = 3'b001;
                    rs1_used = 1'b1; rs2_used = 1'b1;
                end
                7'b1100111: begin                       // JALR
                    rw_raw = 1'b1; pc_raw = 2'b11; ALUOp = 3'b100; operand_A_sel = 2'b10;
                    operand_B_sel = 1'b1; rs1_used = 1'b1;
                end
                7'b1101111: begin                       // JAL
                    rw_raw = 1'b1; pc_raw = 2'b10; ALUOp = 3'b100; operand_A_sel = 2'b10;
                    operand_B_sel = 1'b1;
                end
                7'b0010111: begin                       // AUIPC
                    rw_raw = 1'b1; ALUOp = 3'b110; operand_A_sel = 2'b01;
                    operand_B_sel = 1'b1; extend_sel = 2'b10;
                end
                7'b0110111: begin                       // LUI
                    rw_raw = 1'b1; ALUOp = 3'b101; operand_A_sel = 2'b11;
                    operand_B_sel = 1'b1; extend_sel = 2'b10;
                end
                7'b0001111: ;                           // FENCE: no-op here
                7'b1110011: is_system = 1'b1;           // SYSTEM: always traps
                default:    known = 1'b0;
            endcase
        end
    end

    assign instr_ready = ready_q && (state != FLUSH);
    assign accept      = instr_valid && instr_ready;

    // Privilege violation (custom op in User) and unsupported custom funct3 share cause 2.
    always_comb begin
        trap_det  = 1'b0;
        trap_code = 4'd0;
        if (accept) begin
            if (!known || (is_custom0 && (state == U_MODE || funct3[2:1] != 2'b00))) begin
                trap_det  = 1'b1;
                trap_code = 4'd2;
            end else if (is_system) begin
                trap_det  = 1'b1;
                trap_code = (state == U_MODE) ? 4'd8 : 4'd11;
            end
        end
    end

    assign issue       = accept && !trap_det;
    assign regWrite    = rw_raw && issue;
    assign memRead     = mr_raw && issue;
    assign memtoReg    = mr_raw && issue;
    assign memWrite    = mw_raw && issue;
    assign branch_op   = br_raw && issue;
    assign next_PC_sel = issue ? pc_raw : 2'b00;

    assign mode     = (state == U_MODE) ? 2'b00 : 2'b11;
    assign userMode = (state == U_MODE);
    assign flush    = (state == FLUSH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= M_MODE;
            flush_cnt      <= 4'd0;
            ready_q        <= 1'b0;
            trap_valid     <= 1'b0;
            trap_cause     <= 4'd0;
            trap_prev_mode <= 2'b11;
            illegal_cnt    <= '0;
            user_cycles    <= '0;
        end else begin
            ready_q    <= 1'b1;
            trap_valid <= trap_det;
            if (state == U_MODE && user_cycles != '1)
                user_cycles <= user_cycles + 1'b1;
            if (trap_det) begin
                state          <= FLUSH;
                flush_cnt      <= 4'(FLUSH_CYCLES - 1);
                trap_cause     <= trap_code;
                trap_prev_mode <= mode;
                if (trap_code == 4'd2 && illegal_cnt != '1)
                    illegal_cnt <= illegal_cnt + 1'b1;
            end else begin
                case (state)
                    M_MODE: begin
                        if (accept && is_custom0 && funct3 == 3'b000)
                            state <= U_MODE;                    // UENTER
                        else if (accept && is_custom0 && funct3 == 3'b001)
                            state <= (trap_prev_mode == 2'b00) ? U_MODE : M_MODE; // MRET
                    end
                    U_MODE: ;
                    FLUSH: begin
                        if (flush_cnt == 4'd0)
                            state <= M_MODE;
                        else
                            flush_cnt <= flush_cnt - 1'b1;
                    end
                    default: state <= M_MODE;
                endcase
            end
        end
    end

`ifdef PRIV_CTRL_REPORT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cycle_cnt <= 32'd0;
        else        cycle_cnt <= cycle_cnt + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (report && cycle_cnt >= 32'(PRINT_CYCLES_MIN) && cycle_cnt <= 32'(PRINT_CYCLES_MAX))
            $display("core %0d cyc %0d op %b br %b mr %b m2r %b mw %b rw %b alu %b pc %b a %b b %b ext %b rs1 %b rs2 %b mode %b state %b cause %0d",
                     CORE, cycle_cnt, opcode, branch_op, memRead, memtoReg, memWrite, regWrite,
                     ALUOp, next_PC_sel, operand_A_sel, operand_B_sel, extend_sel, rs1_used,
                     rs2_used, mode, state, trap_cause);
    end
`else
    logic unused_report;
    assign unused_report = ^{report, CORE[0], PRINT_CYCLES_MIN[0], PRINT_CYCLES_MAX[0]};
`endif

endmodule

// File: tb/tb_priv_control_unit.sv
// Directed bench for priv_control_unit: privilege transitions, trap/flush timing, gated decode,
// counter saturation (second instance with CNT_W=2) and reset during FLUSH.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_priv_control_unit;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_CUS  = 7'b0001011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        report = 1'b0;

    logic        instr_ready, branch_op, memRead, memtoReg, memWrite, regWrite;
    logic [2:0]  ALUOp;
    logic [1:0]  next_PC_sel, operand_A_sel, extend_sel, mode, trap_prev_mode;
    logic        operand_B_sel, rs1_used, rs2_used, userMode, trap_valid, flush;
    logic [3:0]  trap_cause;
    logic [15:0] illegal_cnt, user_cycles;

    logic        b_instr_ready, b_branch_op, b_memRead, b_memtoReg, b_memWrite, b_regWrite;
    logic [2:0]  b_ALUOp;
    logic [1:0]  b_next_PC_sel, b_operand_A_sel, b_extend_sel, b_mode, b_trap_prev_mode;
    logic        b_operand_B_sel, b_rs1_used, b_rs2_used, b_userMode, b_trap_valid, b_flush;
    logic [3:0]  b_trap_cause;
    logic [1:0]  b_illegal_cnt, b_user_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    priv_control_unit dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct3(funct3), .branch_op(branch_op), .memRead(memRead),
        .memtoReg(memtoReg), .memWrite(memWrite), .regWrite(regWrite), .ALUOp(ALUOp),
        .next_PC_sel(next_PC_sel), .operand_A_sel(operand_A_sel), .operand_B_sel(operand_B_sel),
        .extend_sel(extend_sel), .rs1_used(rs1_used), .rs2_used(rs2_used), .mode(mode),
        .userMode(userMode), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_prev_mode(trap_prev_mode), .flush(flush), .illegal_cnt(illegal_cnt),
        .user_cycles(user_cycles), .report(report)
    );

    priv_control_unit #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(b_instr_ready),
        .opcode(opcode), .funct3(funct3), .branch_op(b_branch_op), .memRead(b_memRead),
        .memtoReg(b_memtoReg), .memWrite(b_memWrite), .regWrite(b_regWrite), .ALUOp(b_ALUOp),
        .next_PC_sel(b_next_PC_sel), .operand_A_sel(b_operand_A_sel),
        .operand_B_sel(b_operand_B_sel), .extend_sel(b_extend_sel), .rs1_used(b_rs1_used),
        .rs2_used(b_rs2_used), .mode(b_mode), .userMode(b_userMode), .trap_valid(b_trap_valid),
        .trap_cause(b_trap_cause), .trap_prev_mode(b_trap_prev_mode), .flush(b_flush),
        .illegal_cnt(b_illegal_cnt), .user_cycles(b_user_cycles), .report(report)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept one trapping instruction and walk the two FLUSH cycles; an R-type is held valid
    // during the second FLUSH cycle and must not be issued.
    task automatic trap_seq(input logic [6:0] op, input logic [2:0] f3,
                            input logic [3:0] cause, input logic [1:0] pm);
        instr_valid = 1'b1; opcode = op; funct3 = f3;
        #1;
        chk("trap_instr_rw_gated", {31'd0, regWrite}, 32'd0);
        tick();
        instr_valid = 1'b0;
        chk("trap_valid_pulse", {31'd0, trap_valid}, 32'd1);
        chk("trap_cause", {28'd0, trap_cause}, {28'd0, cause});
        chk("trap_prev_mode", {30'd0, trap_prev_mode}, {30'd0, pm});
        chk("flush_c1", {31'd0, flush}, 32'd1);
        chk("ready_c1", {31'd0, instr_ready}, 32'd0);
        chk("mode_in_flush", {30'd0, mode}, 32'd3);
        tick();
        instr_valid = 1'b1; opcode = OP_R; funct3 = 3'd0;
        #1;
        chk("trap_valid_c2", {31'd0, trap_valid}, 32'd0);
        chk("flush_c2", {31'd0, flush}, 32'd1);
        chk("ready_c2", {31'd0, instr_ready}, 32'd0);
        chk("rw_no_accept", {31'd0, regWrite}, 32'd0);
        tick();
        instr_valid = 1'b0;
        chk("flush_done", {31'd0, flush}, 32'd0);
        chk("ready_back", {31'd0, instr_ready}, 32'd1);
        chk("mode_after_flush", {30'd0, mode}, 32'd3);
    endtask

    initial begin
        // ---- reset ----
        #12;
        chk("rst_mode", {30'd0, mode}, 32'd3);
        chk("rst_user", {31'd0, userMode}, 32'd0);
        chk("rst_trap_valid", {31'd0, trap_valid}, 32'd0);
        chk("rst_cause", {28'd0, trap_cause}, 32'd0);
        chk("rst_prev", {30'd0, trap_prev_mode}, 32'd3);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_ill", {16'd0, illegal_cnt}, 32'd0);
        chk("rst_uc", {16'd0, user_cycles}, 32'd0);
        #11 reset = 1'b1;
        tick();
        chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);

        // ---- legal decode in M ----
        instr_valid = 1'b1; opcode = OP_R; #1;
        chk("r_rw", {31'd0, regWrite}, 32'd1);
        chk("r_pc", {30'd0, next_PC_sel}, 32'd0);
        opcode = OP_BR; #1;
        chk("br_op", {31'd0, branch_op}, 32'd1);
        chk("br_pc", {30'd0, next_PC_sel}, 32'd1);
        opcode = OP_JAL; #1;
        chk("jal_pc", {30'd0, next_PC_sel}, 32'd2);
        instr_valid = 1'b0; #1;
        chk("jal_pc_novalid", {30'd0, next_PC_sel}, 32'd0);
        tick();

        // ---- UENTER, 5 idle cycles in U ----
        instr_valid = 1'b1; opcode = OP_CUS; funct3 = 3'b000;
        tick();
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("u_mode", {30'd0, mode}, 32'd0);
        chk("u_userMode", {31'd0, userMode}, 32'd1);
        chk("u_cycles5", {16'd0, user_cycles}, 32'd5);

        // ---- ECALL from U (user_cycles counts the accepting cycle too) ----
        trap_seq(OP_SYS, 3'd0, 4'd8, 2'b00);
        chk("u_cycles_frozen", {16'd0, user_cycles}, 32'd6);

        // ---- MRET returns to U ----
        instr_valid = 1'b1; opcode = OP_CUS; funct3 = 3'b001;
        tick();
        instr_valid = 1'b0;
        chk("mret_mode", {30'd0, mode}, 32'd0);

        // ---- privilege violation: custom op in U ----
        trap_seq(OP_CUS, 3'b000, 4'd2, 2'b00);
        chk("ill_cnt1", {16'd0, illegal_cnt}, 32'd1);
        chk("u_cycles7", {16'd0, user_cycles}, 32'd7);
        chk("uc_sat_w2", {30'd0, b_user_cycles}, 32'd3);

        // ---- illegal traps and ECALL from M ----
        trap_seq(OP_BAD, 3'd0, 4'd2, 2'b11);
        chk("ill_cnt2", {16'd0, illegal_cnt}, 32'd2);
        trap_seq(OP_CUS, 3'b010, 4'd2, 2'b11);
        trap_seq(OP_SYS, 3'd0, 4'd11, 2'b11);
        chk("ill_cnt_ecall", {16'd0, illegal_cnt}, 32'd3);
        trap_seq(OP_BAD, 3'd0, 4'd2, 2'b11);
        trap_seq(OP_BAD, 3'd0, 4'd2, 2'b11);
        chk("ill_cnt5", {16'd0, illegal_cnt}, 32'd5);
        chk("ill_sat_w2", {30'd0, b_illegal_cnt}, 32'd3);

        // ---- reset during first FLUSH cycle ----
        instr_valid = 1'b1; opcode = OP_BAD; funct3 = 3'd0;
        tick();
        instr_valid = 1'b0;
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        chk("mid_rst_mode", {30'd0, mode}, 32'd3);
        chk("mid_rst_cause", {28'd0, trap_cause}, 32'd0);
        chk("mid_rst_tv", {31'd0, trap_valid}, 32'd0);
        chk("mid_rst_ill", {16'd0, illegal_cnt}, 32'd0);
        #2 reset = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("post_rst_flush", {31'd0, flush}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
